// File: rtl/wavetype_selector_pkg.sv
// wavetype_pkg: wave type encoding and sizing helpers shared with the oscillator
package wavetype_pkg;
  typedef enum logic [1:0] {
    SQUARE   = 2'd0,
    SAW      = 2'd1,
    TRIANGLE = 2'd2,
    SINE     = 2'd3
  } wave_t;
  localparam int NUM_WAVES = 4;
  function automatic int mode_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wavetype_selector_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and one-cycle press pulse
module key_debounce
  import wavetype_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, db, db_q;
  logic [CW-1:0] cnt;
  // level flips once the synchronized key has disagreed for DEBOUNCE_CYCLES cycles; press marks rising levels one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      press <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      db_q <= db;
      press <= db & ~db_q;
      if (s2 == db) cnt <= '0;
      else if (cnt == LAST) begin
        db <= ~db;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/wavetype_selector.sv
// wavetype_selector: debounced next/prev buttons stepping a wrapping or saturating mode index
module wavetype_selector
  import wavetype_pkg::*;
#(
  parameter int NUM_MODES = NUM_WAVES,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WRAP = 1,
  parameter int RESET_MODE = 0,
  localparam int MW = mode_width(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 next_key,
  input  logic                 prev_key,
  output logic [MW-1:0]        mode,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 mode_changed
);
  localparam logic [MW-1:0] MAX = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0] RST_MODE = MW'(RESET_MODE);
  logic np, pp;
  logic [MW-1:0] nxt;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst(rst), .key(next_key), .press(np));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (.clk(clk), .rst(rst), .key(prev_key), .press(pp));
  // a lone press steps the index; simultaneous presses cancel; ends wrap or hold
  always_comb begin
    nxt = (np & ~pp) ? ((mode == MAX) ? ((WRAP != 0) ? '0 : mode) : mode + MW'(1)) :
          (pp & ~np) ? ((mode == '0) ? ((WRAP != 0) ? MAX : mode) : mode - MW'(1)) : mode;
  end
  // mode register and change strobe, which fires only on a real value change
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= RST_MODE;
      mode_changed <= 1'b0;
    end else begin
      mode <= nxt;
      mode_changed <= (nxt != mode);
    end
  end
  assign mode_onehot = NUM_MODES'(1) << mode;
endmodule

// File: tb/tb_wavetype_selector.sv
// tb_wavetype_selector: directed table and corner sequences for wrapping and saturating selectors
module tb_wavetype_selector;
  logic clk = 1'b0;
  logic rst, nk, pk;
  logic [1:0] mode_a, mode_b;
  logic [3:0] oh_a, oh_b;
  logic chg_a, chg_b;
  int pass = 0, total = 0, sa = 0, sb = 0;
  always #5 clk = ~clk;
  wavetype_selector #(.DEBOUNCE_CYCLES(4), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .next_key(nk), .prev_key(pk),
    .mode(mode_a), .mode_onehot(oh_a), .mode_changed(chg_a));
  wavetype_selector #(.DEBOUNCE_CYCLES(4), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst), .next_key(nk), .prev_key(pk),
    .mode(mode_b), .mode_onehot(oh_b), .mode_changed(chg_b));
  typedef struct {
    bit r;
    bit n;
    bit p;
    int ea;
    int eb;
    int sa;
    int sb;
  } vec_t;
  vec_t v[19];
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    sa += int'(chg_a);
    sb += int'(chg_b);
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    v[0]  = '{1, 0, 0, 0, 0, 0, 0};
    v[1]  = '{0, 1, 0, 1, 1, 1, 1};
    v[2]  = '{0, 1, 0, 2, 2, 1, 1};
    v[3]  = '{0, 1, 0, 3, 3, 1, 1};
    v[4]  = '{0, 1, 0, 0, 3, 1, 0};
    v[5]  = '{0, 0, 1, 3, 2, 1, 1};
    v[6]  = '{0, 1, 1, 3, 2, 0, 0};
    v[7]  = '{1, 0, 0, 0, 0, 0, 0};
    v[8]  = '{0, 0, 1, 3, 0, 1, 0};
    v[9]  = '{0, 0, 1, 2, 0, 1, 0};
    v[10] = '{0, 0, 1, 1, 0, 1, 0};
    v[11] = '{0, 1, 0, 2, 1, 1, 1};
    v[12] = '{0, 1, 0, 3, 2, 1, 1};
    v[13] = '{0, 1, 0, 0, 3, 1, 1};
    v[14] = '{0, 1, 0, 1, 3, 1, 0};
    v[15] = '{0, 1, 0, 2, 3, 1, 0};
    v[16] = '{0, 0, 1, 1, 2, 1, 1};
    v[17] = '{0, 1, 1, 1, 2, 0, 0};
    v[18] = '{0, 1, 0, 2, 3, 1, 1};
    rst = 1'b1;
    nk = 1'b0;
    pk = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      sa = 0;
      sb = 0;
      if (v[i].r) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sa = 0;
        sb = 0;
        tick();
      end else begin
        nk = v[i].n;
        pk = v[i].p;
        repeat (12) tick();
        nk = 1'b0;
        pk = 1'b0;
        repeat (12) tick();
      end
      chk($sformatf("v%0d mode_a", i), int'(mode_a), v[i].ea);
      chk($sformatf("v%0d mode_b", i), int'(mode_b), v[i].eb);
      chk($sformatf("v%0d onehot_a", i), int'(oh_a), 1 << v[i].ea);
      chk($sformatf("v%0d onehot_b", i), int'(oh_b), 1 << v[i].eb);
      chk($sformatf("v%0d strobes_a", i), sa, v[i].sa);
      chk($sformatf("v%0d strobes_b", i), sb, v[i].sb);
    end
    nk = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midreset mode_a", int'(mode_a), 0);
    chk("midreset mode_b", int'(mode_b), 0);
    chk("midreset chg_a", int'(chg_a), 0);
    rst = 1'b0;
    sa = 0;
    sb = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("requal e%0d mode_a", k), int'(mode_a), (k < 7) ? 0 : 1);
    end
    repeat (30) tick();
    chk("requal strobes_a", sa, 1);
    chk("requal strobes_b", sb, 1);
    chk("requal mode_b", int'(mode_b), 1);
    nk = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    nk = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("latency e%0d mode_a", k), int'(mode_a), (k < 7) ? 0 : 1);
    end
    chk("latency chg_a high", int'(chg_a), 1);
    tick();
    chk("latency chg_a low", int'(chg_a), 0);
    sa = 0;
    repeat (50) tick();
    chk("held strobes_a", sa, 0);
    chk("held mode_a", int'(mode_a), 1);
    nk = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    sa = 0;
    sb = 0;
    for (int k = 0; k < 5; k++) begin
      nk = 1'b1;
      repeat (2) tick();
      nk = 1'b0;
      repeat (2) tick();
    end
    repeat (20) tick();
    chk("bounce mode_a", int'(mode_a), 0);
    chk("bounce mode_b", int'(mode_b), 0);
    chk("bounce strobes_a", sa, 0);
    chk("bounce strobes_b", sb, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/wavetype_selector.md
WAVETYPE_SELECTOR -- requirements
Module: wavetype_selector

Interface
REQ-001 The module SHALL have parameter NUM_MODES, default 4, number of selectable wave modes (legal range 2..16).
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before a key level is accepted (legal range 1..65535).
REQ-003 The module SHALL have parameter WRAP, default 1; 1 means the mode index wraps at the ends, 0 means it saturates.
REQ-004 The module SHALL have parameter RESET_MODE, default 0, mode index loaded by reset (legal range 0..NUM_MODES-1).
REQ-005 The module SHALL have port clk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The module SHALL have port next_key, input, 1 bit, raw asynchronous push-button that advances the mode.
REQ-008 The module SHALL have port prev_key, input, 1 bit, raw asynchronous push-button that steps the mode back.
REQ-009 The module SHALL have port mode, output, MW = max(1, $clog2(NUM_MODES)) bits, the current mode index, registered.
REQ-010 The module SHALL have port mode_onehot, output, NUM_MODES bits, one-hot decode of mode.
REQ-011 The module SHALL have port mode_changed, output, 1 bit, a one-cycle strobe asserted in the first cycle mode holds a new value.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Each synchronized key SHALL feed an independent debouncer: a counter increments while the synchronized level differs from the debounced level and clears whenever they agree.
REQ-014 The debounced level SHALL toggle on the edge at which the counter would reach DEBOUNCE_CYCLES; the counter SHALL clear on that same edge.
REQ-015 The debouncer SHALL produce a press pulse, high for exactly one cycle, on each 0->1 transition of the debounced level; 1->0 transitions SHALL produce no pulse.
REQ-016 The mode register SHALL update on the clock edge following a press pulse, giving a latency of DEBOUNCE_CYCLES+3 edges from the first edge that samples the raw key high.
REQ-017 A next press alone SHALL set mode to mode+1; at mode = NUM_MODES-1 it SHALL go to 0 when WRAP=1 and hold when WRAP=0.
REQ-018 A prev press alone SHALL set mode to mode-1; at mode = 0 it SHALL go to NUM_MODES-1 when WRAP=1 and hold when WRAP=0.
REQ-019 Next and prev press pulses in the same cycle SHALL leave mode unchanged, with no mode_changed.
REQ-020 mode_changed SHALL assert only when the mode value actually changes, so a saturated press produces no strobe.
REQ-021 mode SHALL never leave the range 0..NUM_MODES-1.
REQ-022 mode_onehot SHALL be combinational from mode, with only bit [mode] set.
REQ-023 A key held high SHALL produce exactly one step; a bounce shorter than DEBOUNCE_CYCLES SHALL produce none.

Reset
REQ-024 While rst is high, on each clock edge: mode <= RESET_MODE, mode_changed <= 0, synchronizer flops <= 0, debounced levels <= 0, counters <= 0, press pulses <= 0.
REQ-025 A reset asserted mid-debounce SHALL discard the partial count; a key still held after reset SHALL be re-qualified from zero and SHALL produce one step.
REQ-026 Reset SHALL take precedence over a press pulse in the same cycle.

Structure
REQ-027 The package wavetype_pkg SHALL hold the wave_t enum (SQUARE=0, SAW=1, TRIANGLE=2, SINE=3) and the NUM_WAVES=4 constant shared with the oscillator.
REQ-028 The synchronizer, debounce counter and press-pulse generation SHALL be a sub-module key_debounce (parameter DEBOUNCE_CYCLES), instantiated twice.
REQ-029 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification
REQ-030 With DEBOUNCE_CYCLES=4 and defaults, next_key held high from edge 0 -> mode 0->1 at edge 7, mode_changed high one cycle, and no further step while the key is held for 50 cycles.
REQ-031 next_key toggling every 2 cycles for 20 cycles, then low -> mode stays 0 and mode_changed never asserts.
REQ-032 Four qualified next presses from reset -> mode sequence 1,2,3,0, mode_onehot 0010,0100,1000,0001; prev press from 0 -> 3.
REQ-033 With WRAP=0, three prev presses from 0 -> mode stays 0 with no strobe; five next presses -> mode saturates at 3 with exactly three strobes.
REQ-034 Both keys rising on the same edge and held -> press pulses coincide, and mode and mode_changed are unchanged.
REQ-035 rst pulsed for one cycle while next_key is held and the count is at 2 -> mode=RESET_MODE after the reset edge, then exactly one step 7 edges after rst falls.
